// File: rtl/hs_arbiter.sv
// rtl/hs_arbiter.sv - round-robin arbiter feeding a 4-phase bundled-data handshake
module hs_arbiter #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int SETUP = 2,
  parameter int SYNC  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req_valid,
  output logic [M-1:0]   req_ready,
  input  logic [M*N-1:0] req_data,
  output logic           r_o,
  input  logic           a_o,
  output logic [N-1:0]   d_o,
  output logic [M-1:0]   grant,
  output logic           err
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam logic [PW:0]   M_W        = (PW+1)'(M);
  localparam logic [PW-1:0] LAST_IDX   = PW'(M - 1);
  localparam logic [3:0]    SETUP_LAST = (SETUP > 0) ? 4'(SETUP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP_WAIT,
    REQ_HI,
    REQ_LO
  } state_t;

  state_t          state;
  logic [SYNC-1:0] sync_q;
  logic            a_s;
  logic            a_s_d;
  logic [PW-1:0]   ptr;
  logic [3:0]      cnt;
  logic [PW:0]     sum;
  logic [PW-1:0]   win;
  logic            win_found;
  logic [M-1:0]    win_onehot;
  logic [N-1:0]    win_data;
  logic            accept;
  logic            a_rise;
  logic            a_fall;

  // Acknowledge synchronizer; resets high so a stale high ack is never seen as a new rise
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
      a_s_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], a_o};
      a_s_d  <= a_s;
    end
  end

  assign a_s    = sync_q[SYNC-1];
  assign a_rise = a_s & ~a_s_d;
  assign a_fall = ~a_s & a_s_d;

  // Round-robin search: first valid requester at or after ptr, wrapping past M-1
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    sum       = '0;
    for (int k = 0; k < M; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= M_W) sum = sum - M_W;
      if (!win_found && req_valid[sum[PW-1:0]]) begin
        win       = sum[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  // One-hot form of the winner and its data slice
  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
    win_data        = '0;
    for (int k = 0; k < M; k++) begin
      if (win == PW'(k)) win_data = req_data[k*N +: N];
    end
  end

  // Offer acceptance only in IDLE once the acknowledge has returned low
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !a_s && win_found) req_ready = win_onehot;
  end

  assign accept = |(req_valid & req_ready);

  // Transfer sequencer: accept, hold data SETUP cycles, then run the 4-phase handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      r_o   <= 1'b0;
      grant <= '0;
      d_o   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            d_o   <= win_data;
            grant <= win_onehot;
            ptr   <= (win == LAST_IDX) ? '0 : win + PW'(1);
            cnt   <= '0;
            if (SETUP == 0) begin
              state <= REQ_HI;
              r_o   <= 1'b1;
            end else begin
              state <= SETUP_WAIT;
            end
          end
        end
        SETUP_WAIT: begin
          if (cnt == SETUP_LAST) begin
            state <= REQ_HI;
            r_o   <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        REQ_HI: begin
          if (a_s) begin
            state <= REQ_LO;
            r_o   <= 1'b0;
          end
        end
        REQ_LO: begin
          if (!a_s) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          r_o   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for acknowledge edges that the handshake never asked for
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((a_rise && (state == IDLE || state == SETUP_WAIT)) ||
                 (a_fall && state == REQ_HI)) begin
      err <= 1'b1;
    end
  end

endmodule
